puzzle_board: RTL and testbench



---
 rtl/puzzle_pkg.sv | 31 +++
 rtl/puzzle_board_btn_edge.sv | 22 ++
 rtl/puzzle_board.sv | 72 +++++++
 tb/tb_puzzle_board.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared constants for the 3x3 sliding puzzle: controller status codes,
// preset boards, the solved pattern and a small grid helper.
package puzzle_pkg;

    localparam logic [1:0] CHOSE_BOARD  = 2'b00;
    localparam logic [1:0] GAMING       = 2'b01;
    localparam logic [1:0] GAME_INITIAL = 2'b10;
    localparam logic [1:0] WINNED       = 2'b11;

    // Cell i occupies bits [4i+3:4i]; the hex digits read cell 8 down to cell 0.
    localparam logic [35:0] PRESET [4] = '{
        36'h807654321,   // 1 2 3 / 4 5 6 / 7 0 8
        36'h870654321,   // 1 2 3 / 4 5 6 / 0 7 8
        36'h857604321,   // 1 2 3 / 4 0 6 / 7 5 8
        36'h876543210    // 0 1 2 / 3 4 5 / 6 7 8
    };

    localparam logic [3:0] PRESET_BLANK [4] = '{4'd7, 4'd6, 4'd4, 4'd0};

    localparam logic [35:0] SOLVED = 36'h087654321;

    // Column (0..2) of a grid position 0..8.
    function automatic logic [1:0] col_of(input logic [3:0] pos);
        case (pos)
            4'd1, 4'd4, 4'd7: col_of = 2'd1;
            4'd2, 4'd5, 4'd8: col_of = 2'd2;
            default:          col_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/puzzle_board_btn_edge.sv
// One-bit registered rising-edge detector for a debounced button level.
module btn_edge (
    input  logic clk_d,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    // History updates every cycle; the pulse is registered so it lags the rise by one edge.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= btn;
            rise <= btn & ~prev;
        end
    end

endmodule

// File: rtl/puzzle_board.sv
// Board engine: loads presets while a board is being chosen, applies
// single-button moves of the blank during play, and reports solved state.
module puzzle_board
    import puzzle_pkg::*;
(
    input  logic        clk_d,
    input  logic        rst,
    input  logic [1:0]  game_status,
    input  logic [1:0]  board_sel,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic        active,
    output logic        win_flag,
    output logic [35:0] board_flat,
    output logic [3:0]  blank_pos
);

    logic [3:0] rise;     // {right, left, down, up}
    logic [3:0] target;
    logic       legal;
    logic       playing;
    logic       do_move;
    logic [5:0] tgt_lsb;
    logic [5:0] blank_lsb;

    btn_edge u_edge_up    (.clk_d(clk_d), .rst(rst), .btn(btn_up),    .rise(rise[0]));
    btn_edge u_edge_down  (.clk_d(clk_d), .rst(rst), .btn(btn_down),  .rise(rise[1]));
    btn_edge u_edge_left  (.clk_d(clk_d), .rst(rst), .btn(btn_left),  .rise(rise[2]));
    btn_edge u_edge_right (.clk_d(clk_d), .rst(rst), .btn(btn_right), .rise(rise[3]));

    // Decode a single edge into a target cell; multiple edges fall to the default and are ignored.
    always_comb begin
        target = blank_pos;
        legal  = 1'b0;
        case (rise)
            4'b0001: begin legal = (blank_pos >= 4'd3);          target = blank_pos - 4'd3; end
            4'b0010: begin legal = (blank_pos <= 4'd5);          target = blank_pos + 4'd3; end
            4'b0100: begin legal = (col_of(blank_pos) != 2'd0);  target = blank_pos - 4'd1; end
            4'b1000: begin legal = (col_of(blank_pos) != 2'd2);  target = blank_pos + 4'd1; end
            default: begin legal = 1'b0;                         target = blank_pos;        end
        endcase
        playing   = (game_status == GAMING) || (game_status == GAME_INITIAL);
        do_move   = playing && legal;
        tgt_lsb   = {target, 2'b00};
        blank_lsb = {blank_pos, 2'b00};
    end

    // Board, blank position, move pulse and solved flag registers.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            board_flat <= PRESET[0];
            blank_pos  <= PRESET_BLANK[0];
            active     <= 1'b0;
            win_flag   <= 1'b0;
        end else begin
            active   <= 1'b0;
            win_flag <= (board_flat == SOLVED) && (game_status != CHOSE_BOARD);
            if (game_status == CHOSE_BOARD) begin
                board_flat <= PRESET[board_sel];
                blank_pos  <= PRESET_BLANK[board_sel];
            end else if (do_move) begin
                board_flat[tgt_lsb +: 4]   <= 4'd0;
                board_flat[blank_lsb +: 4] <= board_flat[tgt_lsb +: 4];
                blank_pos                  <= target;
                active                     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_puzzle_board.sv
// Self-checking bench for puzzle_board: directed scenarios plus random moves,
// checked against a grid-level model through a scoreboard of expected moves.
module tb_puzzle_board;

    logic        clk_d = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  game_status = 2'b01;
    logic [1:0]  board_sel = 2'b00;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        active, win_flag;
    logic [35:0] board_flat;
    logic [3:0]  blank_pos;

    puzzle_board dut (
        .clk_d(clk_d), .rst(rst), .game_status(game_status), .board_sel(board_sel),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .active(active), .win_flag(win_flag), .board_flat(board_flat), .blank_pos(blank_pos)
    );

    always #5 clk_d = ~clk_d;

    typedef struct packed {
        logic [35:0] board;
        logic [3:0]  blank;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    localparam int PRE [4][9] = '{
        '{1, 2, 3, 4, 5, 6, 7, 0, 8},
        '{1, 2, 3, 4, 5, 6, 0, 7, 8},
        '{1, 2, 3, 4, 0, 6, 7, 5, 8},
        '{0, 1, 2, 3, 4, 5, 6, 7, 8}
    };

    int m_cells [9];
    int m_blank;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic logic [35:0] model_flat();
        logic [35:0] f;
        for (int i = 0; i < 9; i++) f[4*i +: 4] = 4'(m_cells[i]);
        return f;
    endfunction

    function automatic bit model_solved();
        for (int i = 0; i < 8; i++) if (m_cells[i] != i + 1) return 1'b0;
        return m_cells[8] == 0;
    endfunction

    function automatic void model_load(input int p);
        for (int i = 0; i < 9; i++) begin
            m_cells[i] = PRE[p][i];
            if (PRE[p][i] == 0) m_blank = i;
        end
    endfunction

    // dir: 0 up, 1 down, 2 left, 3 right (direction of the blank)
    function automatic bit model_try(input int dir);
        int r, c, nr, nc, nb;
        r = m_blank / 3;
        c = m_blank % 3;
        nr = r; nc = c;
        case (dir)
            0: nr = r - 1;
            1: nr = r + 1;
            2: nc = c - 1;
            default: nc = c + 1;
        endcase
        if (nr < 0 || nr > 2 || nc < 0 || nc > 2) return 1'b0;
        nb = nr * 3 + nc;
        m_cells[m_blank] = m_cells[nb];
        m_cells[nb] = 0;
        m_blank = nb;
        return 1'b1;
    endfunction

    function automatic logic exp_win();
        return model_solved() && (game_status != 2'b00);
    endfunction

    task automatic check_board(input string tag);
        check({tag, "_board"}, 64'(board_flat), 64'(model_flat()));
        check({tag, "_blank"}, 64'(blank_pos), 64'(m_blank));
        check({tag, "_win"},   64'(win_flag),  64'(exp_win()));
    endtask

    task automatic set_status(input logic [1:0] s);
        @(posedge clk_d); #1;
        game_status = s;
    endtask

    task automatic load_preset(input int p);
        @(posedge clk_d); #1;
        game_status = 2'b00;
        board_sel   = 2'(p);
        repeat (2) @(posedge clk_d);
        model_load(p);
        @(negedge clk_d);
        check_board("load");
    endtask

    // Mask bits: {right, left, down, up}.
    task automatic press(input logic [3:0] mask, input int hold, input string tag);
        int dir;
        @(posedge clk_d); #1;
        {btn_right, btn_left, btn_down, btn_up} = mask;
        if ($countones(mask) == 1 && (game_status == 2'b01 || game_status == 2'b10)) begin
            dir = 0;
            for (int i = 0; i < 4; i++) if (mask[i]) dir = i;
            if (model_try(dir)) exp_q.push_back('{board: model_flat(), blank: 4'(m_blank)});
        end
        repeat (hold) @(posedge clk_d);
        #1;
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        repeat (3) @(posedge clk_d);
        @(negedge clk_d);
        check_board(tag);
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Scoreboard monitor: every active pulse must match the oldest expected move.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_d);
            if (active === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_active", 64'(active), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("move_board", 64'(board_flat), 64'(e.board));
                    check("move_blank", 64'(blank_pos),  64'(e.blank));
                end
            end
        end
    end

    initial begin
        #1000000;
        check("timeout", 64'(1), 64'(0));
        finish_test();
    end

    initial begin
        // Reset values, sampled while reset is still held.
        rst = 1'b1;
        game_status = 2'b01;
        repeat (2) @(posedge clk_d);
        @(negedge clk_d);
        check("rst_board",  64'(board_flat), 64'h807654321);
        check("rst_blank",  64'(blank_pos),  64'(7));
        check("rst_active", 64'(active),     64'(0));
        check("rst_win",    64'(win_flag),   64'(0));

        rst = 1'b0;
        game_status = 2'b00;
        board_sel = 2'd2;
        @(posedge clk_d);
        @(negedge clk_d);
        model_load(2);
        check_board("sel2");
        check("sel2_active", 64'(active), 64'(0));

        // P0, solve with one right move from GAME_INITIAL.
        load_preset(0);
        set_status(2'b10);
        press(4'b1000, 1, "solve_right");
        check("solve_win", 64'(win_flag), 64'(1));

        // P1: illegal left, then up.
        load_preset(1);
        set_status(2'b01);
        press(4'b0100, 1, "illegal_left");
        press(4'b0001, 1, "p1_up");
        check("p1_cell6", 64'(board_flat[27:24]), 64'(4));

        // Simultaneous edges ignored; a long hold yields one move.
        press(4'b0011, 1, "dual_edge");
        press(4'b0001, 10, "hold_up");

        // WINNED freezes the board.
        load_preset(0);
        set_status(2'b01);
        press(4'b1000, 1, "win_again");
        set_status(2'b11);
        for (int i = 0; i < 4; i++) press(4'b0001 << i, 1, "frozen");
        check("frozen_win", 64'(win_flag), 64'(1));
        load_preset(3);

        // Reset lands on the edge a pending legal move would apply.
        load_preset(0);
        set_status(2'b01);
        @(posedge clk_d); #1;
        btn_right = 1'b1;
        @(posedge clk_d); #1;
        rst = 1'b1;
        btn_right = 1'b0;
        @(posedge clk_d); #1;
        rst = 1'b0;
        model_load(0);
        @(negedge clk_d);
        check("rstmove_active", 64'(active), 64'(0));
        check_board("rstmove");
        repeat (3) @(posedge clk_d);
        @(negedge clk_d);
        check_board("rstmove_after");

        // Random play.
        for (int it = 0; it < 80; it++) begin
            logic [3:0] mask;
            logic [1:0] st;
            if (it % 12 == 0) load_preset(int'($urandom_range(0, 3)));
            case ($urandom_range(0, 5))
                0:       st = 2'b11;
                1, 2:    st = 2'b10;
                default: st = 2'b01;
            endcase
            set_status(st);
            if ($urandom_range(0, 9) < 8) mask = 4'b0001 << $urandom_range(0, 3);
            else                          mask = 4'($urandom_range(0, 15));
            press(mask, int'($urandom_range(1, 4)), "rand");
        end

        repeat (5) @(posedge clk_d);
        @(negedge clk_d);
        check("pending_moves", 64'(exp_q.size()), 64'(0));
        finish_test();
    end

endmodule
